// File: rtl/dkong3_audio_pkg.sv
// Shared types and arithmetic helpers for the DK3 sub-CPU audio mixer and its DC blocker.
package dkong3_audio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2,
      FILTER = 2'd3
   } state_e;

   function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
      return in_w + gain_w + 1 + $clog2(num_ch);
   endfunction

   // Inverted-offset rule: (2^(in_w-1)-1) - s; the caller keeps the low in_w bits as signed.
   function automatic logic [31:0] conv_offset(input logic [31:0] s, input int in_w);
      logic [31:0] mid;
      mid = (32'd1 << (in_w - 1)) - 32'd1;
      return mid - s;
   endfunction

   function automatic logic sat_clips(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (v > hi) || (v < lo);
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dkong3_sub_mixer_if.sv
// Sample-side bus of the DK3 sub mixer: per-channel inputs, mixed output and status.
interface dkong3_sub_mixer_if #(
   parameter int NUM_CH = 2,
   parameter int IN_W   = 16,
   parameter int GAIN_W = 8,
   parameter int OUT_W  = 16
);
   import dkong3_audio_pkg::*;

   // I_SAMPLE_CE is a one-cycle offer with no back-pressure: it is accepted only while
   // O_BUSY is low; an offer made while O_BUSY is high is dropped and latches O_OVERRUN.
   // O_VALID is a one-cycle pulse qualifying O_SAMPLE/O_CLIP; there is no ready on that side.
   logic                       I_SAMPLE_CE;
   logic [NUM_CH*IN_W-1:0]     I_SAMPLES;
   logic [NUM_CH*GAIN_W-1:0]   I_GAIN;
   logic [NUM_CH-1:0]          I_MUTE;
   logic [OUT_W-1:0]           O_SAMPLE;
   logic                       O_VALID;
   logic                       O_CLIP;
   logic                       O_BUSY;
   logic                       O_OVERRUN;
   state_e                     O_DBG_STATE;

   modport master (
      output I_SAMPLE_CE, I_SAMPLES, I_GAIN, I_MUTE,
      input  O_SAMPLE, O_VALID, O_CLIP, O_BUSY, O_OVERRUN, O_DBG_STATE
   );

   modport slave (
      input  I_SAMPLE_CE, I_SAMPLES, I_GAIN, I_MUTE,
      output O_SAMPLE, O_VALID, O_CLIP, O_BUSY, O_OVERRUN, O_DBG_STATE
   );

endinterface

// File: rtl/dkong3_dc_block.sv
// One-pole DC blocker y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT), saturated to OUT_W.
module dkong3_dc_block
   import dkong3_audio_pkg::*;
#(
   parameter int OUT_W    = 16,
   parameter int DC_SHIFT = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic signed [OUT_W-1:0] x_i,
   output logic signed [OUT_W-1:0] y_o,
   output logic                    clip_o
);
   logic signed [OUT_W-1:0] x_prev_q;
   logic signed [OUT_W-1:0] y_prev_q;
   logic signed [63:0]      y_raw;

   always_comb begin
      y_raw  = 64'(x_i) - 64'(x_prev_q) + 64'(y_prev_q) - 64'(y_prev_q >>> DC_SHIFT);
      y_o    = OUT_W'(saturate(y_raw, OUT_W));
      clip_o = sat_clips(y_raw, OUT_W);
   end

   // History advances only when the filtered sample is actually emitted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_prev_q <= '0;
         y_prev_q <= '0;
      end else if (en_i) begin
         x_prev_q <= x_i;
         y_prev_q <= y_o;
      end
   end

endmodule

// File: rtl/dkong3_sub_mixer.sv
// Time-multiplexed gain/mute mixer for the DK3 sub-CPU APU streams, one multiplier shared
// across channels. Optional DC blocker after the mix when DCBLOCK_EN is defined.
module dkong3_sub_mixer
   import dkong3_audio_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int IN_W     = 16,
   parameter int GAIN_W   = 8,
   parameter int OUT_W    = 16,
   parameter int DC_SHIFT = 8
) (
   input logic               I_CLK,
   input logic               I_RESET,
   dkong3_sub_mixer_if.slave bus
);
   localparam int ACC_W  = acc_width(IN_W, GAIN_W, NUM_CH);
   localparam int PROD_W = IN_W + GAIN_W + 1;
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [IN_W-1:0]         snap_s_q [NUM_CH];
   logic [IN_W-1:0]         snap_s_d [NUM_CH];
   logic [GAIN_W-1:0]       snap_g_q [NUM_CH];
   logic [GAIN_W-1:0]       snap_g_d [NUM_CH];
   logic [NUM_CH-1:0]       snap_m_q, snap_m_d;
   logic [OUT_W-1:0]        sample_q, sample_d;
   logic                    valid_q, valid_d;
   logic                    clip_q, clip_d;
   logic                    overrun_q, overrun_d;

   logic signed [IN_W-1:0]   conv;
   logic signed [GAIN_W:0]   gain_s;
   logic signed [PROD_W-1:0] term;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [63:0]       mix_r;
   logic [OUT_W-1:0]         mix_sat;
   logic                     mix_clip;

`ifdef DCBLOCK_EN
   logic signed [OUT_W-1:0] x_q, x_d;
   logic                    xclip_q, xclip_d;
   logic signed [OUT_W-1:0] dc_y;
   logic                    dc_clip;

   dkong3_dc_block #(.OUT_W(OUT_W), .DC_SHIFT(DC_SHIFT)) u_dc_block (
      .clk_i  (I_CLK),
      .rst_i  (I_RESET),
      .en_i   (state_q == OUTPUT),
      .x_i    (x_q),
      .y_o    (dc_y),
      .clip_o (dc_clip)
   );
`endif

   // Datapath for the channel selected by idx_q; acc_sum is the accumulator after this channel.
   always_comb begin
      conv   = IN_W'(conv_offset(32'(snap_s_q[idx_q]), IN_W));
      gain_s = signed'({1'b0, snap_g_q[idx_q]});
      if (snap_m_q[idx_q]) term = '0;
      else                 term = PROD_W'(conv) * PROD_W'(gain_s);
      acc_sum  = acc_q + ACC_W'(term);
      mix_r    = 64'(acc_sum >>> (GAIN_W - 1));
      mix_sat  = OUT_W'(saturate(mix_r, OUT_W));
      mix_clip = sat_clips(mix_r, OUT_W);
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      snap_s_d  = snap_s_q;
      snap_g_d  = snap_g_q;
      snap_m_d  = snap_m_q;
      sample_d  = sample_q;
      valid_d   = 1'b0;
      clip_d    = 1'b0;
      overrun_d = overrun_q;
`ifdef DCBLOCK_EN
      x_d       = x_q;
      xclip_d   = xclip_q;
`endif
      if (bus.I_SAMPLE_CE && (state_q != IDLE)) overrun_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (bus.I_SAMPLE_CE) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  snap_s_d[c] = bus.I_SAMPLES[c*IN_W +: IN_W];
                  snap_g_d[c] = bus.I_GAIN[c*GAIN_W +: GAIN_W];
               end
               snap_m_d = bus.I_MUTE;
               acc_d    = '0;
               idx_d    = '0;
               state_d  = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_sum;
            idx_d = idx_q + IDX_W'(1);
            // The final channel's sum is saturated on the way into OUTPUT so the result
            // is visible during the OUTPUT cycle itself.
            if (idx_q == LAST_IDX) begin
               state_d = OUTPUT;
`ifdef DCBLOCK_EN
               x_d     = mix_sat;
               xclip_d = mix_clip;
`else
               sample_d = mix_sat;
               valid_d  = 1'b1;
               clip_d   = mix_clip;
`endif
            end
         end
         OUTPUT: begin
`ifdef DCBLOCK_EN
            sample_d = dc_y;
            valid_d  = 1'b1;
            clip_d   = xclip_q | dc_clip;
            state_d  = FILTER;
`else
            state_d  = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            snap_s_q[c] <= '0;
            snap_g_q[c] <= '0;
         end
         snap_m_q  <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         clip_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef DCBLOCK_EN
         x_q       <= '0;
         xclip_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         snap_s_q  <= snap_s_d;
         snap_g_q  <= snap_g_d;
         snap_m_q  <= snap_m_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         clip_q    <= clip_d;
         overrun_q <= overrun_d;
`ifdef DCBLOCK_EN
         x_q       <= x_d;
         xclip_q   <= xclip_d;
`endif
      end
   end

   assign bus.O_SAMPLE    = sample_q;
   assign bus.O_VALID     = valid_q;
   assign bus.O_CLIP      = clip_q;
   assign bus.O_BUSY      = (state_q != IDLE);
   assign bus.O_OVERRUN   = overrun_q;
   assign bus.O_DBG_STATE = state_q;

endmodule

// File: tb/tb_dkong3_sub_mixer.sv
// Self-checking bench for dkong3_sub_mixer; handles both the plain and DCBLOCK_EN builds.
module tb_dkong3_sub_mixer;
   import dkong3_audio_pkg::*;

   localparam int NUM_CH   = 2;
   localparam int IN_W     = 16;
   localparam int GAIN_W   = 8;
   localparam int OUT_W    = 16;
   localparam int DC_SHIFT = 8;
`ifdef DCBLOCK_EN
   localparam int LAT = NUM_CH + 2;
`else
   localparam int LAT = NUM_CH + 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   logic [OUT_W-1:0] exp_q[$];
   longint xp_m = 0;
   longint yp_m = 0;

   dkong3_sub_mixer_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();

   dkong3_sub_mixer #(
      .NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .DC_SHIFT(DC_SHIFT)
   ) dut (
      .I_CLK   (clk),
      .I_RESET (rst),
      .bus     (bus)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic longint sat_ref(input longint v, output logic clip);
      longint hi;
      longint lo;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -hi - 1;
      clip = (v > hi) || (v < lo);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint mix_ref(input logic [NUM_CH*IN_W-1:0] s,
                                      input logic [NUM_CH*GAIN_W-1:0] g,
                                      input logic [NUM_CH-1:0] m, output logic clip);
      longint acc;
      longint conv;
      acc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         conv = longint'((1 << (IN_W - 1)) - 1) - longint'(s[c*IN_W +: IN_W]);
         if (!m[c]) acc += conv * longint'(g[c*GAIN_W +: GAIN_W]);
      end
      return sat_ref(acc >>> (GAIN_W - 1), clip);
   endfunction

   task automatic expect_out(input logic [NUM_CH*IN_W-1:0] s, input logic [NUM_CH*GAIN_W-1:0] g,
                             input logic [NUM_CH-1:0] m, output logic [OUT_W-1:0] y,
                             output logic clip);
      longint x;
      logic   c1;
      x = mix_ref(s, g, m, c1);
`ifdef DCBLOCK_EN
      begin
         longint v;
         longint yv;
         logic   c2;
         v    = x - xp_m + yp_m - (yp_m >>> DC_SHIFT);
         yv   = sat_ref(v, c2);
         xp_m = x;
         yp_m = yv;
         y    = OUT_W'(yv);
         clip = c1 | c2;
      end
`else
      y    = OUT_W'(x);
      clip = c1;
`endif
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [NUM_CH*IN_W-1:0] rand_samples();
      logic [NUM_CH*IN_W-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c*IN_W +: IN_W] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      return v;
   endfunction

   function automatic logic [NUM_CH*GAIN_W-1:0] rand_gains();
      logic [NUM_CH*GAIN_W-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c*GAIN_W +: GAIN_W] = GAIN_W'($urandom_range(0, (1 << GAIN_W) - 1));
      return v;
   endfunction

   // ---------------- driver ----------------
   task automatic run_mix(input string tag, input logic [NUM_CH*IN_W-1:0] s,
                          input logic [NUM_CH*GAIN_W-1:0] g, input logic [NUM_CH-1:0] m,
                          input bit ce_twice, input bit ce_at_out);
      logic [OUT_W-1:0] y;
      logic clip_e;
      int   cnt;
      int   extra;
      bit   got;
      expect_out(s, g, m, y, clip_e);
      exp_q.push_back(y);
      @(negedge clk);
      bus.I_SAMPLES   = s;
      bus.I_GAIN      = g;
      bus.I_MUTE      = m;
      bus.I_SAMPLE_CE = 1'b1;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < LAT + 4) begin
         @(negedge clk);
         cnt++;
         bus.I_SAMPLE_CE = 1'b0;
         if (cnt == 1) begin
            check({tag, "_busy_accum"}, 64'(bus.O_BUSY), 64'd1);
            bus.I_SAMPLES   = rand_samples();
            bus.I_GAIN      = rand_gains();
            bus.I_MUTE      = ~m;
            bus.I_SAMPLE_CE = ce_twice;
         end
         got = bus.O_VALID;
      end
      check({tag, "_latency"}, 64'(cnt), 64'(LAT));
      check({tag, "_sample"}, 64'(bus.O_SAMPLE), 64'(exp_q.pop_front()));
      check({tag, "_clip"}, 64'(bus.O_CLIP), 64'(clip_e));
      check({tag, "_busy_out"}, 64'(bus.O_BUSY), 64'd1);
      if (ce_at_out) bus.I_SAMPLE_CE = 1'b1;
      @(negedge clk);
      bus.I_SAMPLE_CE = 1'b0;
      check({tag, "_valid_pulse"}, 64'(bus.O_VALID), 64'd0);
      check({tag, "_clip_pulse"}, 64'(bus.O_CLIP), 64'd0);
      check({tag, "_busy_idle"}, 64'(bus.O_BUSY), 64'd0);
      extra = 0;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (bus.O_VALID === 1'b1) extra++;
      end
      check({tag, "_no_extra_valid"}, 64'(extra), 64'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int vcount;
      bus.I_SAMPLE_CE = 1'b0;
      bus.I_SAMPLES   = '0;
      bus.I_GAIN      = '0;
      bus.I_MUTE      = '0;
      #2 rst = 1'b1;
      @(negedge clk);
      check("rst_sample", 64'(bus.O_SAMPLE), 64'd0);
      check("rst_valid", 64'(bus.O_VALID), 64'd0);
      check("rst_clip", 64'(bus.O_CLIP), 64'd0);
      check("rst_busy", 64'(bus.O_BUSY), 64'd0);
      check("rst_overrun", 64'(bus.O_OVERRUN), 64'd0);
      check("rst_state", 64'(bus.O_DBG_STATE), 64'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      // Constant input on ch0, ch1 muted: the DC-blocked build shows the decaying step.
      for (int i = 0; i < 4; i++)
         run_mix("dc_step", {16'h0000, 16'h0000}, {8'd0, 8'd128}, 2'b10, 1'b0, 1'b0);

      run_mix("unity", {16'h7FFF, 16'h0000}, {8'd128, 8'd128}, 2'b00, 1'b0, 1'b0);
      run_mix("max_gain_clip", {16'h0000, 16'h0000}, {8'd255, 8'd255}, 2'b00, 1'b0, 1'b0);
      run_mix("neg_clip", {16'hFFFF, 16'hFFFF}, {8'd128, 8'd128}, 2'b00, 1'b0, 1'b0);
      run_mix("neg_mute", {16'hFFFF, 16'hFFFF}, {8'd128, 8'd128}, 2'b10, 1'b0, 1'b0);
      run_mix("gain_zero", {16'h1234, 16'h0000}, {8'd0, 8'd200}, 2'b00, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++)
         run_mix("random", rand_samples(), rand_gains(), NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)),
                 1'b0, 1'b0);
      check("no_overrun_yet", 64'(bus.O_OVERRUN), 64'd0);

      run_mix("ce_at_output", rand_samples(), rand_gains(), '0, 1'b0, 1'b1);
      check("overrun_from_output", 64'(bus.O_OVERRUN), 64'd1);

      // Clear the sticky flag, then provoke it from the ACCUM phase.
      @(negedge clk);
      rst = 1'b1;
      xp_m = 0;
      yp_m = 0;
      @(negedge clk);
      rst = 1'b0;
      check("overrun_cleared", 64'(bus.O_OVERRUN), 64'd0);
      run_mix("ce_twice", rand_samples(), rand_gains(), '0, 1'b1, 1'b0);
      check("overrun_from_accum", 64'(bus.O_OVERRUN), 64'd1);
      run_mix("after_overrun", rand_samples(), rand_gains(), '0, 1'b0, 1'b0);
      check("overrun_sticky", 64'(bus.O_OVERRUN), 64'd1);

      // Reset during ACCUM aborts the mix without a valid.
      @(negedge clk);
      bus.I_SAMPLES   = rand_samples();
      bus.I_GAIN      = rand_gains();
      bus.I_MUTE      = '0;
      bus.I_SAMPLE_CE = 1'b1;
      @(negedge clk);
      bus.I_SAMPLE_CE = 1'b0;
      check("pre_abort_busy", 64'(bus.O_BUSY), 64'd1);
      rst = 1'b1;
      xp_m = 0;
      yp_m = 0;
      #1;
      check("abort_sample", 64'(bus.O_SAMPLE), 64'd0);
      check("abort_busy", 64'(bus.O_BUSY), 64'd0);
      check("abort_valid", 64'(bus.O_VALID), 64'd0);
      check("abort_overrun", 64'(bus.O_OVERRUN), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      vcount = 0;
      repeat (LAT + 3) begin
         @(negedge clk);
         if (bus.O_VALID === 1'b1) vcount++;
      end
      check("abort_no_valid", 64'(vcount), 64'd0);
      run_mix("after_abort", rand_samples(), rand_gains(), '0, 1'b0, 1'b0);
      run_mix("after_abort2", rand_samples(), rand_gains(), 2'b01, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
